// File: rtl/z_sdpram_reader.sv
// Purpose : streams `length` consecutive words from a simple dual-port RAM, starting
//           at `base_addr` and wrapping at DEPTH, onto a valid/ready stream with a last marker.
// Latency : first beat LATENCY cycles after the start cycle, then one beat per cycle; done one cycle after the last beat.
// Backpres: a stalled output beat (m_valid & ~m_ready) drops ram_ena_r, freezing RAM and tag pipelines.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   start, base_addr, length command; sampled only while idle, length 0 completes without RAM access
//   busy, done               busy while not idle; done pulses for one cycle at the end of a command
//   ram_ena_r, ram_addr_r    RAM read enable (also advances the RAM read pipeline) and address
//   ram_dout                 RAM read data, LATENCY enabled cycles after the address
//   m_valid/m_ready/m_data/m_last  output stream; m_data is ram_dout passed straight through
module z_sdpram_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 192,
    parameter int LATENCY    = 2,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ena_r,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;

    // Tag pipeline: one valid bit and one last bit per RAM pipeline stage.
    // Shifting only on enabled cycles keeps each tag aligned with the word
    // sitting in the matching RAM output register.
    logic [LATENCY-1:0]    tv;
    logic [LATENCY-1:0]    tl;

    logic                  adv;
    logic                  reading;
    logic                  tag_v_in;
    logic                  tag_l_in;
    logic                  final_issue;
    logic                  last_hs;
    logic [ADDR_WIDTH-1:0] next_addr;

    // The pipeline may move whenever the output slot is empty or being
    // consumed. m_ready feeds ram_ena_r combinationally so a stall freezes
    // the RAM in the same cycle the consumer deasserts ready.
    assign adv       = ~m_valid | m_ready;
    assign reading   = (state == S_RUN) || (state == S_DRAIN);
    assign ram_ena_r = adv & reading;
    assign ram_addr_r = addr;

    // Only RUN issues real words; DRAIN issues dummy reads purely to push
    // the in-flight words out of the RAM, tagged invalid.
    assign tag_v_in    = (state == S_RUN);
    assign tag_l_in    = (state == S_RUN) && (remaining == LEN_WIDTH'(1));
    assign final_issue = (state == S_RUN) && ram_ena_r && (remaining == LEN_WIDTH'(1));

    assign next_addr = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + 1'b1;

    assign m_valid = tv[LATENCY-1];
    assign m_last  = tl[LATENCY-1];
    assign m_data  = ram_dout;

    assign last_hs = m_valid & m_ready & m_last;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            tv        <= '0;
            tl        <= '0;
        end else begin
            if (ram_ena_r) begin
                tv[0] <= tag_v_in;
                tl[0] <= tag_l_in;
                for (int i = 1; i < LATENCY; i++) begin
                    tv[i] <= tv[i-1];
                    tl[i] <= tl[i-1];
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_RUN;
                            addr      <= base_addr;
                            remaining <= length;
                        end
                    end
                end

                S_RUN: begin
                    if (ram_ena_r) begin
                        remaining <= remaining - 1'b1;
                        // The final address is held so the dummy reads in
                        // DRAIN stay on an address known to be in range.
                        if (final_issue) begin
                            state <= S_DRAIN;
                        end else begin
                            addr <= next_addr;
                        end
                    end
                end

                S_DRAIN: begin
                    // The last beat can never surface while still in RUN:
                    // it is issued in RUN and needs at least one enabled
                    // cycle to reach the output.
                    if (last_hs) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_sdpram_reader.sv
module tb_z_sdpram_reader;

    localparam int AW  = 8;
    localparam int DW  = 128;
    localparam int DEP = 192;
    localparam int LAT = 2;
    localparam int LW  = 9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          ram_ena_r;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    int errors = 0;
    int checks = 0;

    z_sdpram_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(LAT), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_ena_r(ram_ena_r), .ram_addr_r(ram_addr_r),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: contents plus an enable-gated read pipeline.
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] pipe [LAT];

    always @(posedge clk) begin
        if (ram_ena_r) begin
            pipe[0] <= mem[ram_addr_r];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ram_dout = pipe[LAT-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;      // 0: ready always 1, 1: random ready, 2: stall 3 cycles after 2nd beat
        bit restart;   // drive extra start commands while the first one runs
        int exp_first; // cycle of first m_valid, -1 if none
        int exp_done;  // cycle of done, -1 if not predicted
    } vec_t;

    // Entered one cycle before the start edge (edge 0), just after a rising edge.
    task automatic run_cmd(input int base, input int len, input int mode, input bit restart,
                           input int exp_first, input int exp_done);
        logic [DW-1:0] q_data[$];
        bit            q_last[$];
        int            cyc, first_v, done_c, hs, stall_left, issued, exp_a;
        bit            prev_stall, finished;
        logic [DW-1:0] prev_data;
        logic          prev_last;

        for (int i = 0; i < len; i++) begin
            q_data.push_back(mem[(base + i) % DEP]);
            q_last.push_back(i == len - 1);
        end

        start = 1'b1;
        base_addr = AW'(base);
        length = LW'(len);
        m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        length = LW'($urandom);

        cyc = 0; first_v = -1; done_c = -1; hs = 0; stall_left = 0; issued = 0;
        prev_stall = 0; finished = 0; prev_data = '0; prev_last = 1'b0;

        while (!finished && cyc < 2000) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = (stall_left == 0);
            endcase
            if (restart && cyc >= 1 && cyc <= 3) begin
                start = 1'b1;
                base_addr = AW'(7);
                length = LW'(3);
            end else begin
                start = 1'b0;
            end

            @(negedge clk);
            chk("busy_active", busy, 1);
            if (len == 0) chk("zero_len_ena", ram_ena_r, 0);
            if (ram_ena_r && len > 0) begin
                // Real reads walk the wrapped range, dummy reads stay on the last address.
                exp_a = (issued < len) ? (base + issued) % DEP : (base + len - 1) % DEP;
                chk("ram_addr", ram_addr_r, exp_a);
                issued++;
            end
            if (m_valid && !m_ready) chk("stall_ena", ram_ena_r, 0);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                if (hs >= len) begin
                    chk("beat_count", hs + 1, len);
                end else begin
                    chk("beat_data", m_data, q_data[hs]);
                    chk("beat_last", m_last, q_last[hs]);
                end
                hs++;
                if (mode == 2 && hs == 2) stall_left = 3;
            end else if (!m_ready && stall_left > 0) begin
                stall_left--;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) begin
                done_c = cyc;
                finished = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        chk("done_seen", done_c >= 0, 1);
        chk("beats_total", hs, len);
        chk("first_valid", first_v, exp_first);
        if (exp_done >= 0) chk("done_cycle", done_c, exp_done);

        @(posedge clk); #1;
        start = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", m_valid, 0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[9];

    initial begin
        int b, l, md;

        for (int i = 0; i < 256; i++)
            mem[i] = {32'(i) + 32'h1000_0000, 32'(i * 3), ~32'(i), 32'(i)};

        vecs[0] = '{base: 5,   len: 4,   mode: 0, restart: 0, exp_first: 2,  exp_done: 6};
        vecs[1] = '{base: 190, len: 4,   mode: 0, restart: 0, exp_first: 2,  exp_done: 6};
        vecs[2] = '{base: 0,   len: 0,   mode: 0, restart: 0, exp_first: -1, exp_done: 0};
        vecs[3] = '{base: 0,   len: 6,   mode: 2, restart: 0, exp_first: 2,  exp_done: 11};
        vecs[4] = '{base: 50,  len: 5,   mode: 0, restart: 1, exp_first: 2,  exp_done: 7};
        vecs[5] = '{base: 100, len: 1,   mode: 0, restart: 0, exp_first: 2,  exp_done: 3};
        vecs[6] = '{base: 191, len: 3,   mode: 0, restart: 0, exp_first: 2,  exp_done: 5};
        vecs[7] = '{base: 0,   len: 200, mode: 0, restart: 0, exp_first: 2,  exp_done: 202};
        vecs[8] = '{base: 120, len: 8,   mode: 1, restart: 0, exp_first: 2,  exp_done: -1};

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b1;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ena", ram_ena_r, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", ram_addr_r, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart,
                    vecs[i].exp_first, vecs[i].exp_done);

        // Reset during the second beat of a transfer.
        start = 1'b1;
        base_addr = AW'(0);
        length = LW'(6);
        m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("mid_valid_before", m_valid, 1);
        chk("mid_data_before", m_data, mem[1]);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", m_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ena", ram_ena_r, 0);
        chk("mid_last", m_last, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(10, 2, 0, 0, 2, 4);

        for (int k = 0; k < 30; k++) begin
            b  = $urandom_range(0, DEP - 1);
            l  = $urandom_range(0, 24);
            md = $urandom_range(0, 1);
            run_cmd(b, l, md, 0, (l == 0) ? -1 : LAT,
                    (l == 0) ? 0 : ((md == 0) ? LAT + l : -1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
